mul_issue_ctrl: RTL and testbench
=================================

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 Parameter LEN, default 32, operand width in bits.
REQ-002 Parameter DEPTH, default 4, request-queue entries; power of two, at least 2.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  request offered.
REQ-006 in_ready  out  1  queue can accept a request.
REQ-007 in_a  in  LEN  multiplicand.
REQ-008 in_b  in  LEN  multiplier.
REQ-009 in_signed  in  1  request is two's-complement; ignored unless MUL_ISSUE_SIGNED_EN is defined.
REQ-010 mul_start  out  1  single-cycle start pulse to the shift-add multiplier.
REQ-011 mul_multiplicand  out  LEN  operand A to the multiplier.
REQ-012 mul_multiplier  out  LEN  operand B to the multiplier.
REQ-013 mul_product  in  2*LEN  multiplier result; valid only while mul_finish=1.
REQ-014 mul_finish  in  1  multiplier completion pulse.
REQ-015 out_valid  out  1  result available.
REQ-016 out_ready  in  1  consumer accepts the result.
REQ-017 out_data  out  2*LEN  registered product.

Function
REQ-018 A push occurs when in_valid && in_ready; in_ready SHALL equal !full, independent of in_valid.
REQ-019 The queue SHALL be FIFO with wrap-around pointers and count 0..DEPTH; a push while full cannot occur.
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE.
REQ-021 IDLE: if the queue is non-empty, pop the head into operand registers and go to ISSUE; otherwise stay.
REQ-022 ISSUE: mul_start=1 for exactly this cycle, then go to WAIT.
REQ-023 WAIT: on mul_finish=1, capture mul_product into out_data and go to DONE; otherwise stay.
REQ-024 DONE: out_valid=1; on out_ready=1 go to IDLE; out_data SHALL be stable while out_valid=1 && !out_ready.
REQ-025 mul_multiplicand and mul_multiplier SHALL be driven from the operand registers and held constant from ISSUE through WAIT.
REQ-026 mul_finish outside WAIT SHALL be ignored.
REQ-027 At most one multiplication SHALL be outstanding; no mul_start is issued while in WAIT or DONE.
REQ-028 A push in the same cycle as an IDLE pop SHALL be accepted; count is unchanged that cycle.
REQ-029 Latency: a push at cycle 0 into an empty queue while IDLE gives a pop at cycle 1, mul_start at cycle 2, and out_valid on the cycle after mul_finish is sampled.
REQ-030 out_valid SHALL be registered, with no combinational path from out_ready to out_valid or out_data.

Reset
REQ-031 When rst=1: FSM=IDLE, queue emptied, mul_start=0, out_valid=0, out_data=0, operand registers=0, in_ready=1 after release.
REQ-032 Reset mid-operation (ISSUE, WAIT or DONE) SHALL drop the in-flight request and all queued requests; the multiplier is reset by the same rst.

Configuration
REQ-033 Macro MUL_ISSUE_SIGNED_EN: when defined, each queue entry also stores in_signed.
REQ-034 With the macro, a signed request sends the operand magnitudes, records neg = sign(a) ^ sign(b), and on capture stores the 2*LEN two's-complement negation of mul_product when neg=1.
REQ-035 With the macro, the magnitude of -2^(LEN-1) is 2^(LEN-1) as an unsigned LEN-bit value.
REQ-036 Without the macro, operands pass through unmodified, in_signed is unused, and no sign storage is synthesized.

Structure
REQ-037 Package mul_pkg SHALL hold the FSM state typedef (issue_state_t) and the default LEN and DEPTH constants.
REQ-038 The request queue SHALL be a separate sub-module, mul_issue_fifo, parameterized by width and DEPTH.

Verification
REQ-039 Push a=3, b=5 -> exactly one mul_start pulse; after mul_finish, out_valid=1 with out_data=15.
REQ-040 Push a=0xFFFFFFFF, b=0xFFFFFFFF -> out_data=0xFFFFFFFE00000001.
REQ-041 With the macro, push a=-3, b=5, in_signed=1 -> mul_multiplicand=3, mul_multiplier=5, out_data=0xFFFFFFFFFFFFFFF1.
REQ-042 Hold out_ready=0 and push 5 requests back-to-back -> in_ready=0 after the queue fills; first out_data holds stable; no second mul_start until out_ready=1; all results emerge in order.
REQ-043 Assert rst during WAIT with 2 requests queued -> out_valid=0 and in_ready=1 after release; no result emerges; a later mul_finish pulse is ignored.
REQ-044 Pulse mul_finish while IDLE -> no state change and out_valid stays 0.

Source files
------------

// File: rtl/mul_issue_ctrl_pkg.sv
// ============================================================================
// mul_pkg : shared types and defaults for the multiplier issue controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } issue_state_t;

    localparam int MUL_LEN_DEFAULT   = 32;
    localparam int MUL_DEPTH_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/mul_issue_fifo.sv
// ============================================================================
// mul_issue_fifo : DEPTH-entry request queue with wrap-around pointers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_issue_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int            c_aw        = $clog2(DEPTH);
    localparam logic [c_aw:0] c_depth_cnt = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == c_depth_cnt);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/mul_issue_ctrl.sv
// ============================================================================
// mul_issue_ctrl : queues multiply requests and issues them one at a time to
// a shift-add multiplier. Optional macro MUL_ISSUE_SIGNED_EN adds signed ops.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int LEN   = MUL_LEN_DEFAULT,
    parameter int DEPTH = MUL_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN-1:0]   in_a,
    input  logic [LEN-1:0]   in_b,
    input  logic             in_signed,
    output logic             mul_start,
    output logic [LEN-1:0]   mul_multiplicand,
    output logic [LEN-1:0]   mul_multiplier,
    input  logic [2*LEN-1:0] mul_product,
    input  logic             mul_finish,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*LEN-1:0] out_data
);

`ifdef MUL_ISSUE_SIGNED_EN
    localparam int c_ew = 2*LEN + 1;
`else
    localparam int c_ew = 2*LEN;
`endif

    issue_state_t   r_state;
    issue_state_t   w_state_nxt;
    logic           w_pop;
    logic           w_capture;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic [c_ew-1:0] w_push_data;
    logic [c_ew-1:0] w_head;
    logic [LEN-1:0] w_head_a;
    logic [LEN-1:0] w_head_b;
    logic [LEN-1:0] w_op_a_nxt;
    logic [LEN-1:0] w_op_b_nxt;
    logic [2*LEN-1:0] w_result;

    logic [LEN-1:0]   r_op_a;
    logic [LEN-1:0]   r_op_b;
    logic [2*LEN-1:0] r_out_data;
    logic             r_out_valid;

    assign w_head_a = w_head[2*LEN-1:LEN];
    assign w_head_b = w_head[LEN-1:0];

`ifdef MUL_ISSUE_SIGNED_EN
    logic w_head_signed;
    logic w_neg_nxt;
    logic r_neg;

    assign w_push_data   = {in_signed, in_a, in_b};
    assign w_head_signed = w_head[2*LEN];
    // Negating -2^(LEN-1) in LEN bits yields 2^(LEN-1) read as unsigned.
    assign w_op_a_nxt = (w_head_signed && w_head_a[LEN-1]) ? (~w_head_a + 1'b1) : w_head_a;
    assign w_op_b_nxt = (w_head_signed && w_head_b[LEN-1]) ? (~w_head_b + 1'b1) : w_head_b;
    assign w_neg_nxt  = w_head_signed && (w_head_a[LEN-1] ^ w_head_b[LEN-1]);
    assign w_result   = r_neg ? (~mul_product + 1'b1) : mul_product;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_neg <= 1'b0;
        else if (w_pop) r_neg <= w_neg_nxt;
    end
`else
    logic w_unused_signed;

    assign w_unused_signed = in_signed;
    assign w_push_data     = {in_a, in_b};
    assign w_op_a_nxt      = w_head_a;
    assign w_op_b_nxt      = w_head_b;
    assign w_result        = mul_product;
`endif

    mul_issue_fifo #(
        .WIDTH (c_ew),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (mul_finish) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operands only change on a pop, so they are stable from ISSUE through WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                r_op_a <= w_op_a_nxt;
                r_op_b <= w_op_b_nxt;
            end
            if (w_capture) begin
                r_out_data  <= w_result;
                r_out_valid <= 1'b1;
            end else if (r_state == S_DONE && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready         = !w_fifo_full;
    assign mul_start        = (r_state == S_ISSUE);
    assign mul_multiplicand = r_op_a;
    assign mul_multiplier   = r_op_b;
    assign out_valid        = r_out_valid;
    assign out_data         = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_mul_issue_ctrl.sv
// ============================================================================
// tb_mul_issue_ctrl : directed bench with a queue-based reference model and a
// behavioural shift-add multiplier stand-in.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mul_issue_ctrl;

`ifdef MUL_ISSUE_SIGNED_EN
    localparam bit c_signed_en = 1'b1;
`else
    localparam bit c_signed_en = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_signed = 1'b0;
    logic        mul_start;
    logic [31:0] mul_multiplicand;
    logic [31:0] mul_multiplier;
    logic [63:0] mul_product;
    logic        mul_finish;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;

    logic        model_fin = 1'b0;
    logic [63:0] model_prod = '0;
    logic        man_fin = 1'b0;
    logic [63:0] man_prod = '0;
    bit          auto_mul = 1'b1;
    int          mul_lat = 2;

    assign mul_finish  = model_fin | man_fin;
    assign mul_product = model_fin ? model_prod : man_prod;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;
    int hs_cnt = 0;
    logic [63:0] last_out = '0;
    logic [31:0] last_mul_a = '0;
    logic [31:0] last_mul_b = '0;

    mul_issue_ctrl #(.LEN(32), .DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .in_signed        (in_signed),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product),
        .mul_finish       (mul_finish),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_mag(input logic [31:0] v, input logic s);
        if (s && c_signed_en && v[31]) return 32'd0 - v;
        return v;
    endfunction

    function automatic logic [63:0] exp_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (s && c_signed_en) return 64'(sa * sb);
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Multiplier stand-in: multiplies whatever operands it is started with.
    bit          mbusy = 1'b0;
    int          mcnt = 0;
    logic [63:0] mres = '0;
    always @(negedge clk) begin
        model_fin = 1'b0;
        if (rst) begin
            mbusy = 1'b0;
        end else if (mbusy) begin
            if (mcnt == 0) begin
                model_fin  = 1'b1;
                model_prod = mres;
                mbusy      = 1'b0;
            end else begin
                mcnt--;
            end
        end else if (mul_start && auto_mul) begin
            mbusy = 1'b1;
            mcnt  = mul_lat;
            mres  = {32'b0, mul_multiplicand} * {32'b0, mul_multiplier};
        end
    end

    // Reference model: requests in order, results in order, one outstanding.
    logic [64:0] exp_ops [$];
    logic [63:0] exp_res [$];
    bit          outstanding = 1'b0;
    bit          prev_hold = 1'b0;
    logic [63:0] prev_data = '0;

    always @(negedge clk) begin
        logic [64:0] op;
        if (rst) begin
            exp_ops.delete();
            exp_res.delete();
            outstanding = 1'b0;
            prev_hold   = 1'b0;
            check("rst_out_valid", {63'b0, out_valid}, 64'd0);
            check("rst_mul_start", {63'b0, mul_start}, 64'd0);
        end else begin
            if (in_valid && in_ready) exp_ops.push_back({in_signed, in_a, in_b});
            if (mul_start) begin
                check("start_exclusive", {63'b0, outstanding}, 64'd0);
                if (exp_ops.size() == 0) begin
                    check("start_spurious", 64'd1, 64'd0);
                end else begin
                    op = exp_ops.pop_front();
                    check("multiplicand", {32'b0, mul_multiplicand}, {32'b0, exp_mag(op[63:32], op[64])});
                    check("multiplier", {32'b0, mul_multiplier}, {32'b0, exp_mag(op[31:0], op[64])});
                    exp_res.push_back(exp_prod(op[63:32], op[31:0], op[64]));
                end
                outstanding = 1'b1;
                start_cnt++;
                last_mul_a = mul_multiplicand;
                last_mul_b = mul_multiplier;
            end
            if (prev_hold) check("hold_stable", out_data, prev_data);
            if (out_valid) begin
                if (exp_res.size() == 0) begin
                    check("result_spurious", 64'd1, 64'd0);
                end else begin
                    check("result", out_data, exp_res[0]);
                    if (out_ready) begin
                        void'(exp_res.pop_front());
                        outstanding = 1'b0;
                        hs_cnt++;
                        last_out = out_data;
                    end
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic s);
        bit ok;
        ok = 1'b0;
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("push_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_hs(input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (hs_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("result_timeout", 64'(hs_cnt), 64'(target));
        #1;
    endtask

    initial begin
        int s0;
        int h0;
        bit seen_valid;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {63'b0, out_valid}, 64'd0);
        check("reset_in_ready", {63'b0, in_ready}, 64'd1);
        check("reset_out_data", out_data, 64'd0);
        check("reset_operands", {mul_multiplicand, mul_multiplier}, 64'd0);
        @(posedge clk); #1;

        // 3 x 5
        s0 = start_cnt;
        push(32'd3, 32'd5, 1'b0);
        wait_hs(1);
        check("lit_3x5", last_out, 64'd15);
        check("one_start", 64'(start_cnt - s0), 64'd1);

        // all-ones
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_hs(2);
        check("lit_max", last_out, 64'hFFFF_FFFE_0000_0001);

        // -3 x 5 flagged signed
        push(32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_hs(3);
`ifdef MUL_ISSUE_SIGNED_EN
        check("lit_signed_a", {32'b0, last_mul_a}, 64'd3);
        check("lit_signed_b", {32'b0, last_mul_b}, 64'd5);
        check("lit_signed", last_out, 64'hFFFF_FFFF_FFFF_FFF1);
`else
        check("lit_unsigned_a", {32'b0, last_mul_a}, 64'h0000_0000_FFFF_FFFD);
        check("lit_unsigned", last_out, 64'h0000_0004_FFFF_FFF1);
`endif

        // Back-pressure: 5 requests, consumer stalled
        out_ready = 1'b0;
        mul_lat   = 3;
        s0 = start_cnt;
        h0 = hs_cnt;
        push(32'd11, 32'd13, 1'b0);
        push(32'h8000_0000, 32'h8000_0000, 1'b1);
        push(32'd7, 32'hFFFF_FFFF, 1'b1);
        push(32'h1234_5678, 32'd16, 1'b0);
        push(32'd0, 32'd99, 1'b0);
        @(negedge clk);
        check("full_in_ready", {63'b0, in_ready}, 64'd0);
        repeat (20) @(posedge clk);
        #1;
        check("stall_one_start", 64'(start_cnt - s0), 64'd1);
        check("stall_out_valid", {63'b0, out_valid}, 64'd1);
        check("stall_data", out_data, 64'd143);
        out_ready = 1'b1;
        wait_hs(h0 + 5);
        check("drain_starts", 64'(start_cnt - s0), 64'd5);
        @(negedge clk);
        check("drain_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk); #1;

        // Reset while WAIT with 2 requests queued
        auto_mul = 1'b0;
        s0 = start_cnt;
        h0 = hs_cnt;
        push(32'd7, 32'd9, 1'b0);
        push(32'd2, 32'd2, 1'b0);
        push(32'd4, 32'd4, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("wait_one_start", 64'(start_cnt - s0), 64'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_mid_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk); #1;
        man_prod = 64'h1234;
        man_fin  = 1'b1;
        @(posedge clk); #1;
        man_fin  = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("rst_no_result", {63'b0, seen_valid}, 64'd0);
        check("rst_no_handshake", 64'(hs_cnt - h0), 64'd0);
        check("rst_no_restart", 64'(start_cnt - s0), 64'd1);
        @(posedge clk); #1;

        // Finish pulse while IDLE is ignored
        auto_mul = 1'b1;
        mul_lat  = 1;
        man_prod = 64'hDEAD;
        man_fin  = 1'b1;
        @(posedge clk); #1;
        man_fin  = 1'b0;
        @(negedge clk);
        check("idle_fin_valid", {63'b0, out_valid}, 64'd0);
        @(posedge clk); #1;
        h0 = hs_cnt;
        push(32'd6, 32'd7, 1'b0);
        wait_hs(h0 + 1);
        check("after_idle_fin", last_out, 64'd42);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
